// File: rtl/game_run_timer_pkg.sv
// Shared types and helpers for the MM:SS game run timer.
// Digits are packed BCD {min_tens, min_ones, sec_tens, sec_ones}.
package game_run_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] ONES_MAX     = 4'd9;

    typedef struct packed {
        logic [DIGIT_W-1:0] mt;
        logic [DIGIT_W-1:0] mo;
        logic [DIGIT_W-1:0] st;
        logic [DIGIT_W-1:0] so;
    } mmss_t;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

    // Out-of-range load digits snap to the largest legal value.
    function automatic mmss_t clamp_mmss(input mmss_t v);
        mmss_t r;
        r = v;
        if (r.mt > ONES_MAX)     r.mt = ONES_MAX;
        if (r.mo > ONES_MAX)     r.mo = ONES_MAX;
        if (r.st > SEC_TENS_MAX) r.st = SEC_TENS_MAX;
        if (r.so > ONES_MAX)     r.so = ONES_MAX;
        return r;
    endfunction

endpackage

// File: rtl/game_run_timer_if.sv
// Control and status bundle between the game top and the run timer.
// master drives controls and vsync; slave is the timer.
interface game_run_timer_if;
    logic        vsync;
    logic        run;
    logic        clear;
    logic        mode;
    logic [15:0] load_bcd;
    logic        show_best;
    logic [15:0] cur_nums;
    logic [15:0] best_nums;
    logic [15:0] disp_nums;
    logic        frame_tick;
    logic        sec_tick;
    logic        saturated;
    logic        expired;
    logic        new_best;

    modport master (
        output vsync, run, clear, mode, load_bcd, show_best,
        input  cur_nums, best_nums, disp_nums,
        input  frame_tick, sec_tick, saturated, expired, new_best
    );

    modport slave (
        input  vsync, run, clear, mode, load_bcd, show_best,
        output cur_nums, best_nums, disp_nums,
        output frame_tick, sec_tick, saturated, expired, new_best
    );
endinterface

// File: rtl/game_run_timer_bcd_mmss_counter.sv
// Four-digit BCD minutes:seconds stepper with load and up/down step.
// Limit policy lives in the caller; at_max/at_zero report the bounds.
module bcd_mmss_counter
    import game_run_timer_pkg::*;
#(
    parameter int MAX_MIN_TENS = 9
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  mmss_t load_val,
    input  logic  step,
    input  mode_e down,
    output mmss_t nums,
    output logic  at_max,
    output logic  at_zero
);

    localparam mmss_t MAX_VAL = '{
        mt: DIGIT_W'(MAX_MIN_TENS),
        mo: ONES_MAX,
        st: SEC_TENS_MAX,
        so: ONES_MAX
    };

    mmss_t nxt;

    assign at_max  = (nums == MAX_VAL);
    assign at_zero = (nums == '0);

    always_comb begin
        nxt = nums;
        if (down == MODE_DOWN) begin
            if (nums.so != '0) begin
                nxt.so = nums.so - 4'd1;
            end else begin
                nxt.so = ONES_MAX;
                if (nums.st != '0) begin
                    nxt.st = nums.st - 4'd1;
                end else begin
                    nxt.st = SEC_TENS_MAX;
                    if (nums.mo != '0) begin
                        nxt.mo = nums.mo - 4'd1;
                    end else begin
                        nxt.mo = ONES_MAX;
                        nxt.mt = nums.mt - 4'd1;
                    end
                end
            end
        end else begin
            if (nums.so != ONES_MAX) begin
                nxt.so = nums.so + 4'd1;
            end else begin
                nxt.so = '0;
                if (nums.st != SEC_TENS_MAX) begin
                    nxt.st = nums.st + 4'd1;
                end else begin
                    nxt.st = '0;
                    if (nums.mo != ONES_MAX) begin
                        nxt.mo = nums.mo + 4'd1;
                    end else begin
                        nxt.mo = '0;
                        nxt.mt = nums.mt + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nums <= '0;
        end else if (load) begin
            nums <= load_val;
        end else if (step) begin
            nums <= nxt;
        end
    end

endmodule

// File: rtl/game_run_timer.sv
// Frame-counting MM:SS run clock with up/down modes, flags and best time.
// Frames come from vsync edges; clear restarts and latches the mode.
module game_run_timer
    import game_run_timer_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int TICK_ON_RISE   = 1,
    parameter int MAX_MIN_TENS   = 9
) (
    input logic             clk,
    input logic             rst,
    game_run_timer_if.slave io
);

    localparam int FC_W = $clog2(FRAMES_PER_SEC);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);

    logic            vsync_q;
    logic            run_q;
    mode_e           mode_q;
    logic [FC_W-1:0] frame_cnt;
    logic            saturated_q;
    logic            expired_q;
    logic            frame_tick_q;
    logic            sec_tick_q;
    logic            new_best_q;
    mmss_t           best;
    mmss_t           cur;
    mmss_t           load_val;
    logic            at_max;
    logic            at_zero;

    logic vs_edge;
    logic advance;
    logic wrap;
    logic limit;
    logic hold;
    logic step;
    logic counted;
    logic reach_zero;
    logic run_fall;

    assign vs_edge = (TICK_ON_RISE != 0) ? (io.vsync & ~vsync_q)
                                         : (~io.vsync & vsync_q);
    assign advance = vs_edge & io.run & ~io.clear
                   & ~(saturated_q | expired_q);
    assign wrap    = advance & (frame_cnt == FC_LAST);
    assign limit   = (mode_q == MODE_DOWN) ? at_zero : at_max;
    // A wrap at the limit is swallowed: digits and frame_cnt both hold.
    assign hold    = wrap & limit;
    assign step    = wrap & ~limit;
    assign counted = advance & ~hold;
    assign reach_zero = step & (mode_q == MODE_DOWN)
                      & (cur == mmss_t'(16'h0001));
    assign run_fall = run_q & ~io.run;
    assign load_val = io.mode ? clamp_mmss(mmss_t'(io.load_bcd)) : '0;

    bcd_mmss_counter #(
        .MAX_MIN_TENS(MAX_MIN_TENS)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (io.clear),
        .load_val(load_val),
        .step    (step),
        .down    (mode_q),
        .nums    (cur),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            run_q        <= 1'b0;
            mode_q       <= MODE_UP;
            frame_cnt    <= '0;
            saturated_q  <= 1'b0;
            expired_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            sec_tick_q   <= 1'b0;
        end else begin
            vsync_q      <= io.vsync;
            run_q        <= io.run;
            frame_tick_q <= counted;
            sec_tick_q   <= step;
            if (io.clear) begin
                mode_q      <= mode_e'(io.mode);
                frame_cnt   <= '0;
                saturated_q <= 1'b0;
                expired_q   <= 1'b0;
            end else begin
                if (counted) begin
                    frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
                end
                if (hold && mode_q == MODE_UP) begin
                    saturated_q <= 1'b1;
                end
                // Also catches a freshly loaded 00:00 one cycle after clear.
                if (mode_q == MODE_DOWN && (reach_zero || at_zero)) begin
                    expired_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best       <= '0;
            new_best_q <= 1'b0;
        end else if (run_fall && mode_q == MODE_UP && cur > best) begin
            best       <= cur;
            new_best_q <= 1'b1;
        end else begin
            new_best_q <= 1'b0;
        end
    end

    assign io.cur_nums   = cur;
    assign io.best_nums  = best;
    assign io.disp_nums  = io.show_best ? best : cur;
    assign io.frame_tick = frame_tick_q;
    assign io.sec_tick   = sec_tick_q;
    assign io.saturated  = saturated_q;
    assign io.expired    = expired_q;
    assign io.new_best   = new_best_q;

endmodule

// File: tb/tb_game_run_timer.sv
// Scoreboard bench for game_run_timer: two instances cover rising-edge
// counting with a low minutes limit and falling-edge counting with reset.
module tb_game_run_timer;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    game_run_timer_if ia ();
    game_run_timer_if ib ();

    game_run_timer #(
        .FRAMES_PER_SEC(2),
        .TICK_ON_RISE  (1),
        .MAX_MIN_TENS  (0)
    ) dut_a (
        .clk(clk),
        .rst(rst_a),
        .io (ia.slave)
    );

    game_run_timer #(
        .FRAMES_PER_SEC(3),
        .TICK_ON_RISE  (0),
        .MAX_MIN_TENS  (9)
    ) dut_b (
        .clk(clk),
        .rst(rst_b),
        .io (ib.slave)
    );

    typedef struct packed {
        logic [15:0] nums;
        logic        sec;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] best_qa[$];
    logic [15:0] best_qb[$];

    int checks = 0;
    int failures = 0;
    int a_frames = 0;
    int a_secs = 0;
    int fa, sa, fb, sb;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [15:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h expected=no event", name, act);
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    // Monitors: every frame tick pops one expected {time, sec_tick}.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_a) begin
            if (ia.frame_tick) begin
                a_frames++;
                if (ia.sec_tick) a_secs++;
                if (qa.size() == 0) begin
                    unexpected("a_tick", ia.cur_nums);
                end else begin
                    e = qa.pop_front();
                    chk("a_cur", ia.cur_nums, e.nums);
                    chk("a_sec_tick", 16'(ia.sec_tick), 16'(e.sec));
                end
            end else if (ia.sec_tick) begin
                unexpected("a_sec_tick_alone", ia.cur_nums);
            end
            if (ia.new_best) begin
                if (best_qa.size() == 0)
                    unexpected("a_new_best", ia.best_nums);
                else
                    chk("a_best_pulse", ia.best_nums, best_qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b) begin
            if (ib.frame_tick) begin
                if (qb.size() == 0) begin
                    unexpected("b_tick", ib.cur_nums);
                end else begin
                    e = qb.pop_front();
                    chk("b_cur", ib.cur_nums, e.nums);
                    chk("b_sec_tick", 16'(ib.sec_tick), 16'(e.sec));
                end
            end else if (ib.sec_tick) begin
                unexpected("b_sec_tick_alone", ib.cur_nums);
            end
            if (ib.new_best) begin
                if (best_qb.size() == 0)
                    unexpected("b_new_best", ib.best_nums);
                else
                    chk("b_best_pulse", ib.best_nums, best_qb.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edge_a();
        @(posedge clk);
        #1 ia.vsync = 1'b1;
        @(posedge clk);
        #1 ia.vsync = 1'b0;
    endtask

    task automatic edge_b();
        @(posedge clk);
        #1 ib.vsync = 1'b0;
        @(posedge clk);
        #1 ib.vsync = 1'b1;
    endtask

    task automatic up_edge_a();
        logic s;
        fa++;
        s = 1'b0;
        if (fa == 2) begin
            fa = 0;
            sa++;
            s = 1'b1;
        end
        qa.push_back('{nums: to_bcd(sa), sec: s});
        edge_a();
    endtask

    task automatic up_edge_b();
        logic s;
        fb++;
        s = 1'b0;
        if (fb == 3) begin
            fb = 0;
            sb++;
            s = 1'b1;
        end
        qb.push_back('{nums: to_bcd(sb), sec: s});
        edge_b();
    endtask

    task automatic clear_a(input logic m, input logic [15:0] ld);
        @(posedge clk);
        #1;
        ia.clear = 1'b1;
        ia.mode = m;
        ia.load_bcd = ld;
        @(posedge clk);
        #1 ia.clear = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.vsync = 1'b0; ia.run = 1'b0; ia.clear = 1'b0;
        ia.mode = 1'b0; ia.load_bcd = '0; ia.show_best = 1'b0;
        ib.vsync = 1'b1; ib.run = 1'b0; ib.clear = 1'b0;
        ib.mode = 1'b0; ib.load_bcd = '0; ib.show_best = 1'b0;
        idle(3);
        chk("rst_cur", ia.cur_nums, 16'h0000);
        chk("rst_best", ia.best_nums, 16'h0000);
        chk("rst_disp", ia.disp_nums, 16'h0000);
        chk("rst_flags", {12'h0, ia.saturated, ia.expired,
                          ia.frame_tick, ia.new_best}, 16'h0000);
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(2);
        chk("rel_cur", ia.cur_nums, 16'h0000);
        chk("rel_sec_tick", 16'(ia.sec_tick), 16'h0000);

        // Up count: 4 frames at 2 fps gives 00:02.
        clear_a(1'b0, 16'h0000);
        ia.run = 1'b1;
        fa = 0; sa = 0;
        a_frames = 0; a_secs = 0;
        repeat (4) up_edge_a();
        idle(2);
        chk("up_4edges", ia.cur_nums, 16'h0002);
        chk("up_frames", 16'(a_frames), 16'd4);
        chk("up_secs", 16'(a_secs), 16'd2);
        repeat (2) up_edge_a();
        idle(2);
        best_qa.push_back(16'h0003);
        ia.run = 1'b0;
        idle(3);
        chk("best_first", ia.best_nums, 16'h0003);
        chk("best_pulse_seen", 16'(best_qa.size()), 16'd0);

        // Shorter run must not replace the best.
        clear_a(1'b0, 16'h0000);
        ia.run = 1'b1;
        fa = 0; sa = 0;
        repeat (4) up_edge_a();
        idle(2);
        ia.run = 1'b0;
        idle(3);
        chk("best_kept", ia.best_nums, 16'h0003);
        ia.show_best = 1'b1;
        #1 chk("disp_best", ia.disp_nums, 16'h0003);
        ia.show_best = 1'b0;
        #1 chk("disp_cur", ia.disp_nums, 16'h0002);

        // Clear wins over a coincident edge; load clamps to 99:59.
        @(posedge clk);
        #1;
        ia.run = 1'b1;
        ia.vsync = 1'b1;
        ia.clear = 1'b1;
        ia.mode = 1'b1;
        ia.load_bcd = 16'h9A7C;
        @(posedge clk);
        #1;
        ia.clear = 1'b0;
        ia.vsync = 1'b0;
        idle(2);
        chk("clamp_load", ia.cur_nums, 16'h9959);
        qa.push_back('{nums: 16'h9959, sec: 1'b0});
        qa.push_back('{nums: 16'h9958, sec: 1'b1});
        repeat (2) edge_a();
        idle(2);
        chk("down_step", ia.cur_nums, 16'h9958);
        ia.run = 1'b0;
        idle(3);
        chk("best_down_ignored", ia.best_nums, 16'h0003);

        // Down from 00:01 expires and freezes.
        clear_a(1'b1, 16'h0001);
        ia.run = 1'b1;
        qa.push_back('{nums: 16'h0001, sec: 1'b0});
        qa.push_back('{nums: 16'h0000, sec: 1'b1});
        repeat (2) edge_a();
        idle(2);
        chk("down_zero", ia.cur_nums, 16'h0000);
        chk("expired_set", 16'(ia.expired), 16'd1);
        repeat (2) edge_a();
        idle(2);
        chk("expired_frozen", ia.cur_nums, 16'h0000);
        ia.run = 1'b0;

        // Loading 00:00 in down mode: expired the cycle after clear.
        @(posedge clk);
        #1;
        ia.clear = 1'b1;
        ia.mode = 1'b1;
        ia.load_bcd = 16'h0000;
        @(posedge clk);
        #1;
        ia.clear = 1'b0;
        chk("load0_exp_clr", 16'(ia.expired), 16'd0);
        idle(1);
        chk("load0_exp_set", 16'(ia.expired), 16'd1);

        // Up to the 09:59 ceiling.
        clear_a(1'b0, 16'h0000);
        chk("clr_expired", 16'(ia.expired), 16'd0);
        ia.run = 1'b1;
        fa = 0; sa = 0;
        repeat (1198) up_edge_a();
        idle(2);
        chk("near_max", ia.cur_nums, 16'h0959);
        chk("not_sat_yet", 16'(ia.saturated), 16'd0);
        qa.push_back('{nums: 16'h0959, sec: 1'b0});
        edge_a();
        edge_a();
        idle(2);
        chk("sat_hold", ia.cur_nums, 16'h0959);
        chk("sat_flag", 16'(ia.saturated), 16'd1);
        edge_a();
        idle(2);
        chk("sat_frozen", ia.cur_nums, 16'h0959);
        best_qa.push_back(16'h0959);
        ia.run = 1'b0;
        idle(3);
        chk("best_max", ia.best_nums, 16'h0959);
        clear_a(1'b0, 16'h0000);
        idle(1);
        chk("sat_cleared", 16'(ia.saturated), 16'd0);
        chk("sat_clr_cur", ia.cur_nums, 16'h0000);

        // Falling-edge instance: count to 00:05, bank best, then reset.
        ib.run = 1'b1;
        fb = 0; sb = 0;
        repeat (15) up_edge_b();
        idle(2);
        chk("b_up_5s", ib.cur_nums, 16'h0005);
        best_qb.push_back(16'h0005);
        ib.run = 1'b0;
        idle(3);
        chk("b_best", ib.best_nums, 16'h0005);
        ib.run = 1'b1;
        repeat (2) up_edge_b();
        idle(1);
        @(posedge clk);
        #3 rst_b = 1'b1;
        #1;
        chk("b_rst_cur", ib.cur_nums, 16'h0000);
        chk("b_rst_best", ib.best_nums, 16'h0000);
        chk("b_rst_disp", ib.disp_nums, 16'h0000);
        chk("b_rst_flags", {12'h0, ib.saturated, ib.expired,
                            ib.frame_tick, ib.sec_tick}, 16'h0000);
        qb.delete();
        idle(2);
        rst_b = 1'b0;
        fb = 0; sb = 0;
        idle(3);
        chk("b_rise_ignored", ib.cur_nums, 16'h0000);
        repeat (3) up_edge_b();
        idle(2);
        chk("b_after_rst", ib.cur_nums, 16'h0001);

        idle(3);
        chk("qa_drained", 16'(qa.size()), 16'd0);
        chk("qb_drained", 16'(qb.size()), 16'd0);
        chk("best_qb_drained", 16'(best_qb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_run_timer.md
Name: game_run_timer

Overview:
Parametrised successor to the in-top MM:SS run clock. It counts video frames from vsync edges and produces BCD minutes:seconds for the SevenSegment driver. It adds a count-down mode with a loadable start value, explicit clear, saturation and expiry flags, a best-time register and a display select. It sits beside dino_logic in dino_top, on clk, fed by vsync and the game-active status.

Parameters:
FRAMES_PER_SEC, 60, frames per second; legal range 2..255.
TICK_ON_RISE, 1, 1 = count vsync rising edges; 0 = count falling edges.
MAX_MIN_TENS, 9, upper limit of the minutes-tens digit in up mode; legal range 0..9.

Ports:
clk  in  1  system clock
rst  in  1  reset
vsync  in  1  VGA vsync; generated from a clk-derived clock, so no synchroniser is used
run  in  1  level; time advances only while high
clear  in  1  one-clk pulse; restarts the current time and latches the mode
mode  in  1  0 = up, 1 = down; sampled only when clear is high
load_bcd  in  16  down-mode start value {mt,mo,st,so}; sampled on clear
show_best  in  1  selects best time onto disp_nums
cur_nums  out  16  current time, BCD {min_tens,min_ones,sec_tens,sec_ones}
best_nums  out  16  best up-mode time
disp_nums  out  16  show_best ? best_nums : cur_nums (combinational)
frame_tick  out  1  one-clk pulse per counted frame
sec_tick  out  1  one-clk pulse per second change
saturated  out  1  up mode is held at max time
expired  out  1  down mode has reached 00:00
new_best  out  1  one-clk pulse when best_nums is updated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On reset, every register and output is 0: digits, frame_cnt, vsync_q, run_q, mode_q, best, flags and pulses.
- Edge detection: vsync_q <= vsync every cycle. edge = vsync & ~vsync_q when TICK_ON_RISE=1; edge = ~vsync & vsync_q when TICK_ON_RISE=0.
- Advance condition: advance = edge & run & ~clear & ~(saturated | expired).
- Frame counter: on advance, frame_cnt increments (width $clog2(FRAMES_PER_SEC)). At FRAMES_PER_SEC-1 it wraps to 0 and the digits step once, in the same cycle.
- Up-mode stepping: BCD increment. so 9->0 carries to st; st 5->0 carries to mo; mo 9->0 carries to mt. At MAX_MIN_TENS,9,5,9 the digits hold, saturated goes to 1, and frame_cnt holds.
- Down-mode stepping: BCD decrement with borrows (so 0->9, st 0->5, mo 0->9). On reaching 00:00, expired goes to 1 and the counter freezes.
- Loading a down-mode 00:00: expired is set on the cycle after clear.
- Clear: clear has priority over a coincident edge. It resets frame_cnt to 0 and saturated/expired to 0, and sets mode_q <= mode.
  - mode=0: digits are set to 00:00.
  - mode=1: digits are set to load_bcd. Any digit above 9 is clamped to 9; a sec_tens digit above 5 is clamped to 5.
- Tick outputs: frame_tick and sec_tick are registered and asserted the cycle after the update, aligned with the new cur_nums. sec_tick fires only when the digits actually change.
- Best time:
  - run_q <= run every cycle.
  - On run falling (run_q & ~run) with mode_q=0, if cur_nums > best_nums (unsigned 16-bit compare; valid because BCD ordering is monotone), best is loaded and new_best pulses the next cycle.
  - best_nums is unaffected by clear and by down mode.
- Simultaneous events: a run falling edge and a digit step in the same cycle compare against the pre-step value.
- Reset mid-count: immediate zero; mode returns to up.

Decomposition:
- Shared package: BCD digit width (4), max values for seconds-tens (5) and ones digits (9), and the clamp helper function.
- Sub-module bcd_mmss_counter: a 4-digit up/down BCD stepper with load, a step enable, and at_max/at_zero outputs. Counting policy, flags, best time and edge logic stay in game_run_timer.

Test Plan:
- FRAMES_PER_SEC=2, up mode, run=1, 4 vsync rising edges -> cur_nums=16'h0002, 2 sec_tick pulses, 4 frame_tick pulses.
- Preload via down mode load 16'h0001, clear, run; after 2 edges -> cur_nums=16'h0000, expired=1; further edges -> no change.
- Up mode forced near max (MAX_MIN_TENS=0, run to 09:59) -> one more second holds 16'h0959 and sets saturated=1.
- Up run to 00:03, drop run -> best_nums=16'h0003 and new_best pulse; clear, run to 00:02, drop run -> best stays 16'h0003, no new_best; show_best=1 -> disp_nums=16'h0003.
- clear asserted in the same cycle as a vsync edge with mode=1, load_bcd=16'h9A7C -> cur_nums=16'h9959 (clamped), frame_cnt=0, no tick.
- rst asserted mid-count at 00:05 with TICK_ON_RISE=0 -> all outputs 0 immediately; after release, only falling vsync edges count.
